simpleio_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the simple I/O peripheral's LED, DISP1 and DISP2 byte registers among several hardware requesters, such as game logic, a score counter and a status blinker. It sits between those requesters and the peripheral's register write strobes. It serialises the writes into single-cycle strobes. After each write it can hold the target stable for a number of CPLD frames, so every written value is shifted out to the board at least once before it can be overwritten.

---
 rtl/simpleio_arb_pkg.sv | 18 +
 rtl/simpleio_wr_arbiter_rr_pick.sv | 28 ++
 rtl/simpleio_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_simpleio_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simpleio_arb_pkg.sv
// Shared codes for the simple I/O write arbiter: target selects, FSM states
// and the hold-counter width.
package simpleio_arb_pkg;

  localparam logic [1:0] TGT_LED   = 2'd0;
  localparam logic [1:0] TGT_DISP1 = 2'd1;
  localparam logic [1:0] TGT_DISP2 = 2'd2;
  localparam logic [1:0] TGT_RSVD  = 2'd3;

  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/simpleio_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = ptr_i;
    for (int i = 0; i < N; i++) begin
      cand = (cand == IW'(N-1)) ? '0 : cand + 1'b1;
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/simpleio_wr_arbiter.sv
// Round-robin arbiter serialising LED/DISP1/DISP2 byte writes with an optional
// frame hold. SIMPLEIO_ARB_PRIO0_EN gives requester 0 absolute, hold-free priority.
module simpleio_wr_arbiter
  import simpleio_arb_pkg::*;
#(
  parameter  int C_NUM_REQ     = 4,
  parameter  int C_HOLD_FRAMES = 1,
  localparam int GW            = $clog2(C_NUM_REQ)
) (
  input  logic                   Bus2IP_Clk,
  input  logic                   Bus2IP_Resetn,
  input  logic [C_NUM_REQ-1:0]   req,
  input  logic [2*C_NUM_REQ-1:0] req_sel,
  input  logic [8*C_NUM_REQ-1:0] req_data,
  input  logic                   frame_done,
  output logic [C_NUM_REQ-1:0]   ack,
  output logic [C_NUM_REQ-1:0]   err,
  output logic                   led_wr,
  output logic                   disp1_wr,
  output logic                   disp2_wr,
  output logic [7:0]             wr_data,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  state_e                  state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d, gid_q, gid_d;
  logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_NUM_REQ-1:0]    ack_q, ack_d, err_q, err_d;
  logic                    led_q, led_d, d1_q, d1_d, d2_q, d2_d;
  logic [7:0]              wd_q, wd_d;

  logic [C_NUM_REQ-1:0]    pick_req;
  logic                    pick_vld;
  logic [GW-1:0]           pick_idx;
  logic                    win_vld, ptr_upd, skip_hold;
  logic [GW-1:0]           win;
  logic [1:0]              win_sel;
  logic [7:0]              win_data;

  rr_pick #(.N(C_NUM_REQ)) u_pick (
    .req_i (pick_req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  // Winner resolution; with priority, requester 0 bypasses the pointer entirely.
  always_comb begin
`ifdef SIMPLEIO_ARB_PRIO0_EN
    pick_req  = req & ~C_NUM_REQ'(1);
    win_vld   = req[0] | pick_vld;
    win       = req[0] ? '0 : pick_idx;
    ptr_upd   = ~req[0];
    skip_hold = (gid_q == '0);
`else
    pick_req  = req;
    win_vld   = pick_vld;
    win       = pick_idx;
    ptr_upd   = 1'b1;
    skip_hold = 1'b0;
`endif
  end

  assign win_sel  = req_sel[{win, 1'b0} +: 2];
  assign win_data = req_data[{win, 3'b000} +: 8];

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= GW'(C_NUM_REQ-1);
      gid_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      led_q   <= 1'b0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      led_q   <= led_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_WRITE;
          gid_d   = win;
          if (ptr_upd) ptr_d = win;
        end
      end
      ST_WRITE: begin
        // A frame_done landing here is deliberately dropped by the clear.
        cnt_d = '0;
        if (C_HOLD_FRAMES > 0 && !(|err_q) && !skip_hold) state_d = ST_HOLD;
        else                                              state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (frame_done) begin
          if (cnt_q + 1'b1 == HOLD_CNT_W'(C_HOLD_FRAMES)) state_d = ST_IDLE;
          else                                             cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-state: strobes are launched on the IDLE->WRITE edge.
  always_comb begin
    ack_d = '0;
    err_d = '0;
    led_d = 1'b0;
    d1_d  = 1'b0;
    d2_d  = 1'b0;
    wd_d  = '0;
    if (state_q == ST_IDLE && win_vld) begin
      if (win_sel == TGT_RSVD) begin
        err_d[win] = 1'b1;
      end else begin
        ack_d[win] = 1'b1;
        wd_d       = win_data;
        led_d      = (win_sel == TGT_LED);
        d1_d       = (win_sel == TGT_DISP1);
        d2_d       = (win_sel == TGT_DISP2);
      end
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign led_wr   = led_q;
  assign disp1_wr = d1_q;
  assign disp2_wr = d2_q;
  assign wr_data  = wd_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simpleio_wr_arbiter.sv
// Bench for simpleio_wr_arbiter: two instances (hold 0 and hold 2), vector
// table, directed multi-cycle sequences and randomized requesters vs a model.
module tb_simpleio_wr_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;
`ifdef SIMPLEIO_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req [2];
  logic [2*N-1:0] sel [2];
  logic [8*N-1:0] dat [2];
  logic           fd  [2];
  logic [N-1:0]   ack [2];
  logic [N-1:0]   err [2];
  logic           led [2];
  logic           d1  [2];
  logic           d2  [2];
  logic [7:0]     wd  [2];
  logic [GW-1:0]  gid [2];
  logic           busy[2];

  simpleio_wr_arbiter #(.C_NUM_REQ(N), .C_HOLD_FRAMES(0)) dut0 (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .req(req[0]), .req_sel(sel[0]),
    .req_data(dat[0]), .frame_done(fd[0]), .ack(ack[0]), .err(err[0]),
    .led_wr(led[0]), .disp1_wr(d1[0]), .disp2_wr(d2[0]), .wr_data(wd[0]),
    .grant_id(gid[0]), .busy(busy[0]));

  simpleio_wr_arbiter #(.C_NUM_REQ(N), .C_HOLD_FRAMES(2)) dut2 (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n), .req(req[1]), .req_sel(sel[1]),
    .req_data(dat[1]), .frame_done(fd[1]), .ack(ack[1]), .err(err[1]),
    .led_wr(led[1]), .disp1_wr(d1[1]), .disp2_wr(d2[1]), .wr_data(wd[1]),
    .grant_id(gid[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic          led, d1, d2;
    logic [7:0]    wd;
    logic [N-1:0]  ack, err;
    logic          busy;
    logic [GW-1:0] gid;
  } out_t;

  typedef struct {
    bit            rst;
    logic [N-1:0]  req;
    logic [2*N-1:0] sel;
    logic [8*N-1:0] dat;
    out_t          e;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic out_t mk(logic l, logic a, logic b, logic [7:0] w, logic [N-1:0] ak,
                              logic [N-1:0] er, logic bs, logic [GW-1:0] g);
    out_t o;
    o.led = l; o.d1 = a; o.d2 = b; o.wd = w; o.ack = ak; o.err = er; o.busy = bs; o.gid = g;
    return o;
  endfunction

  task automatic chk_out(input int k, input string tag, input out_t e);
    chk($sformatf("%s[%0d] led", tag, k), led[k], e.led);
    chk($sformatf("%s[%0d] disp1", tag, k), d1[k], e.d1);
    chk($sformatf("%s[%0d] disp2", tag, k), d2[k], e.d2);
    if (e.led | e.d1 | e.d2) chk($sformatf("%s[%0d] wr_data", tag, k), wd[k], e.wd);
    chk($sformatf("%s[%0d] ack", tag, k), ack[k], e.ack);
    chk($sformatf("%s[%0d] err", tag, k), err[k], e.err);
    chk($sformatf("%s[%0d] busy", tag, k), busy[k], e.busy);
    chk($sformatf("%s[%0d] grant_id", tag, k), gid[k], e.gid);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: "phase" 0 free / 1 write cycle / 2 waiting on frames_left.
  int   H[2] = '{0, 2};
  int   m_phase[2], m_left[2], m_ptr[2];
  bit   m_hold[2];
  out_t m_out[2];

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_left[k] = 0; m_ptr[k] = N-1; m_hold[k] = 0;
    m_out[k] = mk(0, 0, 0, 8'h00, '0, '0, 0, '0);
  endtask

  task automatic model_step(input int k);
    out_t o;
    int w, c, s;
    o = mk(0, 0, 0, 8'h00, '0, '0, 0, m_out[k].gid);
    case (m_phase[k])
      0: begin
        w = -1;
        if (PRIO && req[k][0]) w = 0;
        else
          for (int i = 1; i <= N; i++) begin
            c = (m_ptr[k] + i) % N;
            if (w < 0 && req[k][c] && !(PRIO && c == 0)) w = c;
          end
        if (w >= 0) begin
          s = int'(sel[k][2*w +: 2]);
          o.gid = GW'(w);
          if (!(PRIO && w == 0)) m_ptr[k] = w;
          m_phase[k] = 1;
          if (s == 3) o.err[w] = 1'b1;
          else begin
            o.ack[w] = 1'b1;
            o.wd  = dat[k][8*w +: 8];
            o.led = (s == 0); o.d1 = (s == 1); o.d2 = (s == 2);
          end
          m_hold[k] = (s != 3) && H[k] > 0 && !(PRIO && w == 0);
        end
      end
      1: begin
        if (m_hold[k]) begin m_phase[k] = 2; m_left[k] = H[k]; end
        else m_phase[k] = 0;
      end
      default: begin
        if (fd[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = 0;
        end
      end
    endcase
    o.busy = (m_phase[k] != 0);
    m_out[k] = o;
  endtask

  vec_t tbl[$];
  bit   pend[2][N];

  task automatic addv(bit r, logic [N-1:0] q, logic [2*N-1:0] s, logic [8*N-1:0] d, out_t e);
    vec_t v;
    v.rst = r; v.req = q; v.sel = s; v.dat = d; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic clear_in();
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; sel[k] = '0; dat[k] = '0; fd[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes [4];
    logic [1:0] sels  [4];
    logic [GW-1:0] got [3];
    int w, n;
    bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
    sels  = '{2'd0, 2'd1, 2'd2, 2'd0};
    clear_in();

    // Vector table for the hold-0 instance.
    addv(1, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    addv(0, 4'b0001, 8'h00, 32'h000000A5, mk(1, 0, 0, 8'hA5, 4'b0001, 4'b0000, 1, 0));
    addv(0, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    addv(1, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    for (int i = 0; i < 5; i++) begin
      w = PRIO ? 0 : i % 4;
      addv(0, 4'b1111, 8'h24, 32'h43322110,
           mk(sels[w] == 0, sels[w] == 1, sels[w] == 2, bytes[w], 4'(1 << w), 4'b0000, 1, GW'(w)));
      addv(0, 4'b1111, 8'h24, 32'h43322110, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, GW'(w)));
    end
    addv(0, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    addv(0, 4'b0010, 8'h0C, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0010, 1, 1));
    addv(0, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 1));
    addv(0, 4'b0100, 8'h20, 32'h00770000, mk(0, 0, 1, 8'h77, 4'b0100, 4'b0000, 1, 2));
    addv(0, 4'b0000, 8'h00, 32'h0, mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 2));

    foreach (tbl[i]) begin
      req[0] = tbl[i].req; sel[0] = tbl[i].sel; dat[0] = tbl[i].dat;
      if (tbl[i].rst) rst_n = 1'b0;
      tick();
      chk_out(0, $sformatf("vec%0d", i), tbl[i].e);
      if (i == 0) chk_out(1, "reset", mk(0, 0, 0, 8'h00, '0, '0, 0, 0));
      rst_n = 1'b1;
    end

    // Hold of 2 frames; the frame_done in the WRITE cycle must not count.
    do_reset();
    req[1] = 4'b0110; sel[1] = 8'h10; dat[1] = 32'h00221100;
    tick(); chk_out(1, "hold_w1", mk(1, 0, 0, 8'h11, 4'b0010, 4'b0000, 1, 1));
    fd[1] = 1'b1; req[1] = 4'b0100;
    tick(); chk_out(1, "hold_fdw", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 1));
    fd[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out(1, "hold_wait", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 1));
    end
    fd[1] = 1'b1;
    tick(); chk_out(1, "hold_f1", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 1));
    fd[1] = 1'b0;
    tick(); tick(); chk_out(1, "hold_gap", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 1));
    fd[1] = 1'b1;
    tick(); chk_out(1, "hold_f2", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 1));
    fd[1] = 1'b0;
    tick(); chk_out(1, "hold_w2", mk(0, 1, 0, 8'h22, 4'b0100, 4'b0000, 1, 2));
    req[1] = 4'b0000;
    tick(); fd[1] = 1'b1; tick(); tick(); fd[1] = 1'b0;
    chk_out(1, "hold_done", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 2));

    // Reserved target: err only, no hold afterwards.
    req[1] = 4'b0010; sel[1] = 8'h0C;
    tick(); chk_out(1, "rsvd_err", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0010, 1, 1));
    req[1] = 4'b0000;
    tick(); chk_out(1, "rsvd_nohold", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 1));

    // Asynchronous reset in the middle of a hold.
    req[1] = 4'b0100; sel[1] = 8'h00; dat[1] = 32'h00990000;
    tick(); chk_out(1, "mid_w", mk(1, 0, 0, 8'h99, 4'b0100, 4'b0000, 1, 2));
    req[1] = 4'b0000;
    tick(); chk_out(1, "mid_hold", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 2));
    #2 rst_n = 1'b0;
    #1 chk_out(1, "mid_rst", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    req[1] = 4'b1001; sel[1] = 8'h00; dat[1] = 32'h0000005A;
    tick(); chk_out(1, "post_rst", mk(1, 0, 0, 8'h5A, 4'b0001, 4'b0000, 1, 0));
    req[1] = 4'b0000;
    tick();

    if (PRIO) begin
      do_reset();
      req[1] = 4'b0111; sel[1] = 8'h00; dat[1] = 32'h00332211;
      for (int i = 0; i < 3; i++) begin
        tick(); chk_out(1, "p0_w", mk(1, 0, 0, 8'h11, 4'b0001, 4'b0000, 1, 0));
        tick(); chk_out(1, "p0_nohold", mk(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0));
      end
      req[1] = 4'b0110; fd[1] = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
        tick();
        if (ack[1] != '0) begin got[n] = gid[1]; n++; end
      end
      chk("p0 grants seen", n, 3);
      for (int i = 0; i < n; i++) chk($sformatf("p0 order%0d", i), got[i], (i % 2 == 0) ? 1 : 2);
      clear_in();
    end

    // Randomized requesters obeying the hold-until-ack protocol.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      for (int r = 0; r < N; r++) pend[k][r] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk_out(k, "rand", m_out[k]);
        for (int r = 0; r < N; r++) begin
          if (pend[k][r] && (m_out[k].ack[r] || m_out[k].err[r])) begin
            pend[k][r] = 1'b0; req[k][r] = 1'b0;
          end else if (!pend[k][r] && $urandom_range(3) == 0) begin
            pend[k][r] = 1'b1; req[k][r] = 1'b1;
            sel[k][2*r +: 2] = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
            dat[k][8*r +: 8] = 8'($urandom);
          end
        end
        fd[k] = ($urandom_range(2) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
